// File: rtl/ysyx_23060077_mdu_div_ctrl_if.sv
// ysyx_23060077_mdu_div_ctrl_if: dispatch, writeback and divider-side signals of the divide controller
interface ysyx_23060077_mdu_div_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_op;
  logic [DATA_WIDTH-1:0] in_src1;
  logic [DATA_WIDTH-1:0] in_src2;
  logic [4:0]            in_rd;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [4:0]            out_rd;
  logic                  div_valid;
  logic                  div_signed;
  logic [DATA_WIDTH-1:0] div_dividend;
  logic [DATA_WIDTH-1:0] div_divisor;
  logic                  div_ready;
  logic                  div_out_valid;
  logic [DATA_WIDTH-1:0] div_quotient;
  logic [DATA_WIDTH-1:0] div_remainder;
  modport master (
    output in_valid, in_op, in_src1, in_src2, in_rd, flush, out_ready,
           div_ready, div_out_valid, div_quotient, div_remainder,
    input  in_ready, out_valid, out_result, out_rd,
           div_valid, div_signed, div_dividend, div_divisor
  );
  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_rd, flush, out_ready,
           div_ready, div_out_valid, div_quotient, div_remainder,
    output in_ready, out_valid, out_result, out_rd,
           div_valid, div_signed, div_dividend, div_divisor
  );
endinterface

// File: rtl/ysyx_23060077_mdu_div_ctrl.sv
// ysyx_23060077_mdu_div_ctrl: RV32M divide issue/completion controller with local div-by-zero/overflow results
module ysyx_23060077_mdu_div_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input logic clock,
  input logic reset,
  ysyx_23060077_mdu_div_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  state_t state, state_next;
  logic rem_sel;
  logic accept;
  logic div_zero;
  logic overflow;
  logic [DATA_WIDTH-1:0] bypass_result;
  assign accept = bus.in_valid && !bus.flush && state == IDLE;
  assign div_zero = bus.in_src2 == '0;
  assign overflow = !bus.in_op[0] && bus.in_src1 == MIN_NEG && bus.in_src2 == '1;
  assign bypass_result = div_zero ? (bus.in_op[1] ? bus.in_src1 : '1) : (bus.in_op[1] ? '0 : MIN_NEG);
  assign bus.in_ready = state == IDLE;
  assign bus.div_valid = state == ISSUE && bus.div_ready && !bus.flush;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? ((div_zero || overflow) ? DONE : ISSUE) : IDLE;
      ISSUE:   state_next = bus.flush ? IDLE : bus.div_valid ? WAIT : ISSUE;
      WAIT:    state_next = bus.div_out_valid ? (bus.flush ? IDLE : DONE) : bus.flush ? DRAIN : WAIT;
      DONE:    state_next = (bus.out_ready || bus.flush) ? IDLE : DONE;
      DRAIN:   state_next = bus.div_out_valid ? IDLE : DRAIN;
      default: state_next = IDLE;
    endcase
  end
  // Operands are written only on accept so the divider sees them stable until the return to IDLE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      rem_sel          <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_result   <= '0;
      bus.out_rd       <= '0;
      bus.div_dividend <= '0;
      bus.div_divisor  <= '0;
      bus.div_signed   <= 1'b0;
    end else begin
      state         <= state_next;
      bus.out_valid <= state_next == DONE;
      if (accept) begin
        rem_sel          <= bus.in_op[1];
        bus.div_dividend <= bus.in_src1;
        bus.div_divisor  <= bus.in_src2;
        bus.div_signed   <= !bus.in_op[0];
        bus.out_rd       <= bus.in_rd;
        bus.out_result   <= bypass_result;
      end
      if (state == WAIT && bus.div_out_valid && !bus.flush)
        bus.out_result <= rem_sel ? bus.div_remainder : bus.div_quotient;
    end
  end
endmodule

// File: tb/tb_ysyx_23060077_mdu_div_ctrl.sv
// tb_ysyx_23060077_mdu_div_ctrl: scoreboard bench with a 34-cycle behavioural divider behind the controller
module tb_ysyx_23060077_mdu_div_ctrl;
  typedef struct {
    logic [31:0] res, a, b;
    logic [4:0]  rd;
    logic        sgn, byp, issued, seen;
    int          acc, lat;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0, failures = 0, cyc = 0, rel_cyc = 0;
  exp_t exp_q[$];
  bit hs_prev = 0;
  bit dbusy = 0;
  int dcnt = 0, dhold = 2;
  ysyx_23060077_mdu_div_ctrl_if #(.DATA_WIDTH(32)) bus ();
  ysyx_23060077_mdu_div_ctrl #(.DATA_WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  initial forever @(posedge clock) cyc++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    x = op[0] ? longint'({32'h0, a}) : longint'($signed(a));
    y = op[0] ? longint'({32'h0, b}) : longint'($signed(b));
    return op[1] ? 32'(x % y) : 32'(x / y);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  // Divider model: 34 edges from start capture to the result pulse, reads operands live at completion
  task automatic div_clear();
    dbusy = 0; dcnt = 0; dhold = 2;
    bus.div_ready = 0; bus.div_out_valid = 0;
  endtask
  initial begin
    bit start;
    bus.div_quotient = 0; bus.div_remainder = 0;
    div_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin div_clear(); continue; end
      start = bus.div_valid;
      #1;
      if (!reset) begin div_clear(); continue; end
      bus.div_out_valid = 0;
      if (dhold > 0) dhold--;
      if (dbusy) begin
        dcnt--;
        if (dcnt == 0) begin
          dbusy = 0;
          bus.div_out_valid = 1;
          bus.div_quotient  = ref_res({1'b0, ~bus.div_signed}, bus.div_dividend, bus.div_divisor);
          bus.div_remainder = ref_res({1'b1, ~bus.div_signed}, bus.div_dividend, bus.div_divisor);
        end
      end else if (start) begin
        dbusy = 1; dcnt = 34;
      end
      bus.div_ready = !dbusy && dhold == 0;
    end
  end
  // Monitor and scoreboard
  initial begin
    exp_t e, n;
    bit allowed;
    forever begin
      @(negedge clock);
      if (!reset) begin exp_q.delete(); hs_prev = 0; continue; end
      if (hs_prev) chk("in_ready_after_done", bus.in_ready, 1);
      hs_prev = 0;
      if (dbusy || bus.div_out_valid) chk("in_ready_while_div_busy", bus.in_ready, 0);
      allowed = exp_q.size() > 0 && !exp_q[0].byp && !exp_q[0].issued;
      chk("div_valid_allowed", bus.div_valid && !allowed, 0);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (bus.div_valid) exp_q[0].issued = 1;
        chk("div_dividend", bus.div_dividend, e.a);
        chk("div_divisor", bus.div_divisor, e.b);
        chk("div_signed", bus.div_signed, e.sgn);
        if (e.lat >= 0 && !e.byp && cyc == e.acc + 1 && !bus.flush) chk("div_valid_at_n1", bus.div_valid, 1);
        if (bus.out_valid) begin
          chk("out_result", bus.out_result, e.res);
          chk("out_rd", bus.out_rd, e.rd);
          if (!e.seen) begin
            if (e.lat >= 0) chk("latency", cyc - e.acc, e.lat);
            exp_q[0].seen = 1;
          end
        end
        if ((bus.out_valid && bus.out_ready) || bus.flush) begin
          hs_prev = bus.out_valid;
          void'(exp_q.pop_front());
        end
      end else chk("out_valid_idle", bus.out_valid, 0);
      if (bus.in_valid && bus.in_ready && !bus.flush) begin
        n.a = bus.in_src1; n.b = bus.in_src2; n.rd = bus.in_rd;
        n.sgn = !bus.in_op[0];
        n.res = ref_res(bus.in_op, bus.in_src1, bus.in_src2);
        n.byp = bus.in_src2 == 0 || (!bus.in_op[0] && bus.in_src1 == 32'h8000_0000 && bus.in_src2 == 32'hFFFF_FFFF);
        n.issued = 0; n.seen = 0; n.acc = cyc;
        n.lat = n.byp ? 1 : (cyc - rel_cyc > 4 ? 37 : -1);
        exp_q.push_back(n);
      end
    end
  end
  task automatic chk_reset();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_rd", bus.out_rd, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_div_valid", bus.div_valid, 0);
    chk("rst_div_dividend", bus.div_dividend, 0);
    chk("rst_div_divisor", bus.div_divisor, 0);
    chk("rst_div_signed", bus.div_signed, 0);
  endtask
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n = 0;
    bus.in_op = op; bus.in_src1 = a; bus.in_src2 = b; bus.in_rd = rd; bus.in_valid = 1;
    do begin @(negedge clock); n++; end while (!bus.in_ready && n < 300);
    chk("accept_timeout", bus.in_ready, 1);
    @(posedge clock); #1;
    bus.in_valid = 0; bus.in_src1 = $urandom; bus.in_src2 = $urandom; bus.in_rd = 5'($urandom);
  endtask
  task automatic finish_op(input bit rnd);
    int n = 0;
    do begin
      if (rnd) begin bus.out_ready = $urandom % 3 != 0; bus.flush = $urandom % 40 == 0; end
      @(negedge clock); n++;
      if (bus.in_ready) break;
      @(posedge clock); #1;
    end while (n < 300);
    chk("op_timeout", bus.in_ready, 1);
    @(posedge clock); #1;
    bus.flush = 0; bus.out_ready = 1;
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    send(op, a, b, rd);
    finish_op(0);
  endtask
  initial begin
    int n;
    logic [31:0] a, b;
    bus.in_valid = 0; bus.in_op = 0; bus.in_src1 = 0; bus.in_src2 = 0; bus.in_rd = 0;
    bus.flush = 0; bus.out_ready = 1;
    #3 chk_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1; rel_cyc = cyc;
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd8);
    run(2'b11, 32'd100, 32'd7, 5'd9);
    run(2'b00, 32'd5, 32'd0, 5'd10);
    run(2'b11, 32'd5, 32'd0, 5'd11);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    // flush in WAIT, then a normal op behind the drain
    send(2'b00, 32'd100, 32'd7, 5'd15);
    repeat (9) @(posedge clock);
    #1 bus.flush = 1;
    @(posedge clock); #1 bus.flush = 0;
    run(2'b00, 32'd9, 32'd3, 5'd16);
    // flush in ISSUE: divider must never start
    send(2'b01, 32'd77, 32'd5, 5'd17);
    bus.flush = 1;
    @(posedge clock); #1 bus.flush = 0;
    finish_op(0);
    // flush coincident with the divider result pulse
    send(2'b10, 32'd1234, 32'd10, 5'd18);
    repeat (35) @(posedge clock);
    #2 bus.flush = 1;
    @(posedge clock); #1 bus.flush = 0;
    finish_op(0);
    // flush in DONE
    bus.out_ready = 0;
    send(2'b00, 32'd50, 32'd5, 5'd19);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.out_valid && n < 100);
    chk("done_reached", bus.out_valid, 1);
    @(posedge clock); #1 bus.flush = 1;
    @(posedge clock); #1 bus.flush = 0;
    finish_op(0);
    // back-pressure for 10 cycles
    bus.out_ready = 0;
    send(2'b11, 32'd1000, 32'd33, 5'd20);
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.out_valid && n < 100);
    chk("bp_valid", bus.out_valid, 1);
    repeat (10) @(posedge clock);
    #1 bus.out_ready = 1;
    finish_op(0);
    // asynchronous reset while in WAIT
    send(2'b00, 32'd999, 32'd4, 5'd21);
    repeat (10) @(posedge clock);
    #2 reset = 0;
    #1 chk_reset();
    @(negedge clock);
    @(posedge clock); #1 reset = 1; rel_cyc = cyc;
    run(2'b01, 32'd81, 32'd9, 5'd22);
    for (int i = 0; i < 40; i++) begin
      case ($urandom % 8)
        0: begin a = $urandom; b = 0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom % 200; b = 1 + $urandom % 15; end
        3: begin a = $urandom; b = -(1 + $urandom % 9); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      send(2'($urandom), a, b, 5'($urandom));
      finish_op(1);
    end
    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
